pwm_multi_ch: RTL

- Parametrised successor to the three-phase PWM stage behind the FOC top: N_CH centre-aligned PWM channels driven from one shared triangle counter.
- Complementary high/low outputs per channel with programmable dead time.
- Duty updates arrive over a valid/ready handshake and are double-buffered, so they only take effect at a period boundary.
- Sits between the inverse-Clarke/SVM stage and the gate drivers.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_deadtime.sv | 59 +++++
 rtl/pwm_multi_ch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default sizes for the multi-channel PWM block.
//   DEF_N_CH / DEF_CNT_W / DEF_DT_W : default channel count and widths
//   duty_t                          : duty word at the default counter width
//   dir_t                           : triangle counter direction (UP, DOWN)
package pwm_pkg;

    localparam int DEF_N_CH  = 3;
    localparam int DEF_CNT_W = 19;
    localparam int DEF_DT_W  = 8;

    typedef logic [DEF_CNT_W-1:0] duty_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate pair with dead-time insertion for one channel.
//   clk, rst   : clock, synchronous active-high reset
//   en         : 0 clears the channel and holds both gates low
//   raw        : ideal PWM level from the comparator
//   dead_time  : number of both-low cycles inserted after each raw edge
//   hi, lo     : high-side / low-side gate drives, registered (1-cycle latency)
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DEF_DT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            hi,
    output logic            lo
);

    localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

    logic            raw_q;
    logic [DT_W-1:0] dt_cnt;

    // Every raw edge drops both gates and (re)starts the dead-time count;
    // the gate matching raw turns on once the count has run out. Since the
    // non-edge path only ever drives raw / !raw, both gates can never be high.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            raw_q  <= 1'b0;
            dt_cnt <= '0;
            hi     <= 1'b0;
            lo     <= 1'b0;
        end else begin
            raw_q <= raw;
            if (raw != raw_q) begin
                if (dead_time == '0) begin
                    dt_cnt <= '0;
                    hi     <= raw;
                    lo     <= !raw;
                end else begin
                    dt_cnt <= dead_time;
                    hi     <= 1'b0;
                    lo     <= 1'b0;
                end
            end else if (dt_cnt > DT_ONE) begin
                dt_cnt <= dt_cnt - DT_ONE;
                hi     <= 1'b0;
                lo     <= 1'b0;
            end else begin
                dt_cnt <= '0;
                hi     <= raw;
                lo     <= !raw;
            end
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N_CH centre-aligned PWM channels sharing one triangle counter.
//   clk, rst      : clock, synchronous active-high reset
//   en            : run enable; 0 holds the counter at 0 and forces gates low
//   period_top    : triangle apex, captured at each period start
//   dead_time     : dead-time cycles, captured at each period start
//   duty_in       : packed duties, channel 0 in the LSBs
//   duty_valid    : duty_in valid
//   duty_ready    : pending buffer empty
//   pwm_hi/pwm_lo : per-channel complementary gate drives
//   cnt_out       : current triangle count
//   cnt_up        : 1 while counting up (counter direction state)
//   period_start  : pulse in the cycle where cnt==0 and a new period begins
//
// Handshake: a duty set transfers when duty_valid & duty_ready are both high
// in a cycle; duty_in is then held in the pending buffer and duty_ready stays
// low until that set moves into the active registers at a period start.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DT_W  = DEF_DT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_W-1:0]      period_top,
    input  logic [DT_W-1:0]       dead_time,
    input  logic [N_CH*CNT_W-1:0] duty_in,
    input  logic                  duty_valid,
    output logic                  duty_ready,
    output logic [N_CH-1:0]       pwm_hi,
    output logic [N_CH-1:0]       pwm_lo,
    output logic [CNT_W-1:0]      cnt_out,
    output logic                  cnt_up,
    output logic                  period_start
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]      cnt;
    dir_t                  dir;
    logic [CNT_W-1:0]      p_sh;
    logic [DT_W-1:0]       dt_sh;
    logic [N_CH*CNT_W-1:0] duty_act;
    logic [N_CH*CNT_W-1:0] duty_pend;
    logic                  pend_full;
    logic                  start;
    logic                  accept;
    logic [CNT_W-1:0]      p_eff;
    logic [N_CH-1:0]       raw;

    assign start  = en & ~rst & (cnt == '0) & (dir == UP);
    assign accept = duty_valid & ~pend_full;
    // The step out of cnt==0 already uses the apex being captured this cycle.
    assign p_eff  = start ? period_top : p_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dir       <= UP;
            p_sh      <= '0;
            dt_sh     <= '0;
            duty_act  <= '0;
            duty_pend <= '0;
            pend_full <= 1'b0;
        end else begin
            // accept needs an empty buffer and the transfer a full one, so
            // the two pend_full updates below never meet in one cycle.
            if (accept) begin
                duty_pend <= duty_in;
                pend_full <= 1'b1;
            end
            if (start) begin
                p_sh  <= period_top;
                dt_sh <= dead_time;
                if (pend_full) begin
                    duty_act  <= duty_pend;
                    pend_full <= 1'b0;
                end
            end

            if (!en) begin
                cnt <= '0;
                dir <= UP;
            end else if (dir == UP) begin
                if (cnt >= p_eff) begin
                    // P=0 stays at 0; P=1 has no down leg (0,1,0,1,...).
                    if (p_eff <= CNT_ONE) begin
                        cnt <= '0;
                        dir <= UP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        dir <= DOWN;
                    end
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                if (cnt <= CNT_ONE) begin
                    cnt <= '0;
                    dir <= UP;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign raw[i] = (cnt < duty_act[i*CNT_W +: CNT_W]);

        pwm_deadtime #(
            .DT_W(DT_W)
        ) u_dt (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .raw       (raw[i]),
            .dead_time (dt_sh),
            .hi        (pwm_hi[i]),
            .lo        (pwm_lo[i])
        );
    end

    assign duty_ready   = ~pend_full;
    assign cnt_out      = cnt;
    assign cnt_up       = (dir == UP);
    assign period_start = start;

endmodule
